// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: the debounce decision
// taken on every clock and the helper that derives it.
package input_conditioner_pkg;

  localparam int T_DEFAULT = 4;

  typedef enum logic [1:0] {
    DB_HOLD   = 2'd0,
    DB_COUNT  = 2'd1,
    DB_COMMIT = 2'd2
  } db_action_e;

  // A match always restarts the count; only the T-th consecutive mismatch commits.
  function automatic db_action_e db_action(input logic mismatch, input logic at_limit);
    db_action_e act;
    if (!mismatch) begin
      act = DB_HOLD;
    end else if (at_limit) begin
      act = DB_COMMIT;
    end else begin
      act = DB_COUNT;
    end
    return act;
  endfunction

endpackage

// File: rtl/input_conditioner_sync_2ff.sv
// Two-flop synchronizer bringing one asynchronous bit into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync0_q;
  logic sync1_q;

  // Two-stage capture; only the second stage is allowed downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= d;
      sync1_q <= sync0_q;
    end
  end

  assign q = sync1_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects one raw input pin; the level
// changes only after T consecutive clocks of disagreement.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter  int T  = T_DEFAULT,
  localparam int CW = $clog2(T + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic conditioned,
  output logic rising,
  output logic falling
);

  logic          pin_sync;
  logic          mismatch;
  db_action_e    action;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          cond_q;
  logic          cond_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pin),
    .q       (pin_sync)
  );

  assign mismatch = pin_sync ^ cond_q;
  assign action   = db_action(mismatch, count_q == CW'(T - 1));

  // Next-state for the debounce counter, level and one-cycle edge pulses.
  always_comb begin
    count_d = count_q;
    cond_d  = cond_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (action)
      DB_HOLD: begin
        count_d = {CW{1'b0}};
      end
      DB_COUNT: begin
        count_d = count_q + CW'(1);
      end
      DB_COMMIT: begin
        count_d = {CW{1'b0}};
        cond_d  = pin_sync;
        rise_d  = pin_sync;
        fall_d  = ~pin_sync;
      end
      default: begin
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // State registers; reset clears any pulse in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {CW{1'b0}};
      cond_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cond_q  <= cond_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign conditioned = cond_q;
  assign rising      = rise_q;
  assign falling     = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and random checks of input_conditioner with T=4 on a 500-unit clock.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int T = 4;

  logic clk;
  logic reset_n;
  logic pin;
  logic conditioned;
  logic rising;
  logic falling;

  int n_total;
  int n_bad;

  input_conditioner #(.T(T)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pin         (pin),
    .conditioned (conditioned),
    .rising      (rising),
    .falling     (falling)
  );

  initial clk = 1'b0;
  always #250 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    #100;
    pin = v;
  endtask

  int   n_rise;
  int   n_fall;
  int   hist [0:255];
  int   n;
  logic m_cond;
  logic m_prev;
  logic all_diff;
  int   s;
  int   model_changes;
  int   dut_pulses;
  logic val;

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b1;
    pin     = 1'b1;

    // reset with pin high, before any clock edge
    #5 reset_n = 1'b0;
    #5;
    chk("rst_cond", conditioned, 1'b0);
    chk("rst_rise", rising, 1'b0);
    chk("rst_fall", falling, 1'b0);
    tick();
    tick();
    chk("rst_hold_cond", conditioned, 1'b0);
    #100 reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("rel_cond_e5", conditioned, 1'b0);
      if (e == 6) begin
        chk("rel_cond_e6", conditioned, 1'b1);
        chk("rel_rise_e6", rising, 1'b1);
        chk("rel_fall_e6", falling, 1'b0);
      end
      if (e == 7) begin
        chk("rel_rise_e7", rising, 1'b0);
        chk("rel_cond_e7", conditioned, 1'b1);
      end
    end

    // clean fall
    drive(1'b0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("fall_cond_e5", conditioned, 1'b1);
      if (e == 6) begin
        chk("fall_cond_e6", conditioned, 1'b0);
        chk("fall_fall_e6", falling, 1'b1);
        chk("fall_rise_e6", rising, 1'b0);
      end
      if (e == 7) chk("fall_fall_e7", falling, 1'b0);
    end

    // clean rise
    drive(1'b1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        chk("rise_cond_e5", conditioned, 1'b0);
        chk("rise_rise_e5", rising, 1'b0);
      end
      if (e == 6) begin
        chk("rise_cond_e6", conditioned, 1'b1);
        chk("rise_rise_e6", rising, 1'b1);
        chk("rise_fall_e6", falling, 1'b0);
      end
      if (e == 7) chk("rise_rise_e7", rising, 1'b0);
    end

    // reset while a falling pulse is in flight
    drive(1'b0);
    repeat (6) tick();
    chk("midrst_fall_pre", falling, 1'b1);
    #50 reset_n = 1'b0;
    #1;
    chk("midrst_fall", falling, 1'b0);
    chk("midrst_cond", conditioned, 1'b0);
    #100 reset_n = 1'b1;
    dut_pulses = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      dut_pulses += int'(rising) + int'(falling);
    end
    chk("midrst_no_pulse", dut_pulses, 0);
    chk("midrst_cond_after", conditioned, 1'b0);

    // glitch of 3 clocks is rejected
    drive(1'b1);
    repeat (3) tick();
    drive(1'b0);
    n_rise = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_rise += int'(rising);
    end
    chk("glitch_cond", conditioned, 1'b0);
    chk("glitch_rise", n_rise, 0);

    // 3-clock glitch, one low clock, then stable high: full T needed again
    drive(1'b1);
    repeat (3) tick();
    drive(1'b0);
    tick();
    drive(1'b1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("regl_cond_e5", conditioned, 1'b0);
      if (e == 6) begin
        chk("regl_cond_e6", conditioned, 1'b1);
        chk("regl_rise_e6", rising, 1'b1);
      end
    end
    drive(1'b0);
    repeat (8) tick();
    chk("regl_back_low", conditioned, 1'b0);

    // bounce: toggle every clock for 10 clocks, then settle high
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2) == 0);
      tick();
      n_rise += int'(rising);
      n_fall += int'(falling);
    end
    chk("bounce_cond_toggling", conditioned, 1'b0);
    drive(1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_rise += int'(rising);
      n_fall += int'(falling);
      if (e == 5) chk("bounce_cond_e5", conditioned, 1'b0);
      if (e == 6) begin
        chk("bounce_cond_e6", conditioned, 1'b1);
        chk("bounce_rise_e6", rising, 1'b1);
      end
    end
    chk("bounce_n_rise", n_rise, 1);
    chk("bounce_n_fall", n_fall, 0);
    chk("bounce_cond_end", conditioned, 1'b1);

    // random: level flips once the last T synchronized samples all disagree
    #50 reset_n = 1'b0;
    pin = 1'b0;
    tick();
    tick();
    #100 reset_n = 1'b1;
    m_cond        = 1'b0;
    n             = 0;
    model_changes = 0;
    dut_pulses    = 0;
    for (int v = 0; v < 100; v++) begin
      val = 1'($urandom_range(1, 0));
      for (int c = 0; c < 2; c++) begin
        drive(val);
        tick();
        hist[n] = int'(pin);
        all_diff = 1'b1;
        for (int j = 0; j < T; j++) begin
          s = (n - 2 - j >= 0) ? hist[n - 2 - j] : 0;
          if (s == int'(m_cond)) all_diff = 1'b0;
        end
        m_prev = m_cond;
        if (all_diff) begin
          m_cond = ~m_cond;
          model_changes++;
        end
        dut_pulses += int'(rising) + int'(falling);
        chk("rnd_cond", conditioned, m_cond);
        chk("rnd_rise", rising, m_cond & ~m_prev);
        chk("rnd_fall", falling, m_prev & ~m_cond);
        chk("rnd_excl", rising & falling, 1'b0);
        n++;
      end
    end
    chk("rnd_pulse_count", dut_pulses, model_changes);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions one raw, asynchronous, possibly bouncing input pin into a clean, clock-synchronous level.
- Also produces single-cycle rising-edge and falling-edge pulses of that clean level.
- Used at every external button/switch/serial input before the signal reaches synchronous logic.
- Pipeline: 2-flop synchronizer → debounce counter → edge detector.

Parameters:
- T, 4, debounce length: the synchronized input must differ from the current conditioned level for T consecutive clocks before the conditioned level changes. Legal range T ≥ 1.
- CW, $clog2(T+1), counter width in bits (derived; do not override).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- pin, input, 1, raw asynchronous input; may change at any time relative to clk.
- conditioned, output, 1, synchronized, debounced level of pin.
- rising, output, 1, one-cycle pulse when conditioned goes 0→1.
- falling, output, 1, one-cycle pulse when conditioned goes 1→0.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed):
  - sync0, sync1, counter, conditioned, rising and falling are all cleared to 0.
  - Held in reset while reset_n=0; normal operation resumes on the first clk edge after release.
- Synchronizer: on each clk edge, sync0 <= pin, then sync1 <= sync0. Only sync1 is used downstream; pin is never sampled elsewhere.
- Debounce, on each clk edge with mismatch = (sync1 != conditioned):
  - mismatch=0: counter <= 0; conditioned holds; rising <= 0; falling <= 0.
  - mismatch=1 and counter < T-1: counter <= counter+1; conditioned holds; rising <= 0; falling <= 0.
  - mismatch=1 and counter == T-1: conditioned <= sync1; counter <= 0; rising <= sync1; falling <= !sync1.
- Outputs: rising, falling and conditioned are registered; there are no combinational paths from pin.
- Glitch rejection: any return of sync1 to the conditioned level before T consecutive mismatches clears the counter. A glitch shorter than T clocks (after synchronization) therefore never reaches conditioned.
- Latency: pin stable from before edge k → sync1 valid after edge k+1 → conditioned changes at edge k+1+T.
  - Total delay is T+2 clock edges (T=4: 6 edges).
- Pulse width:
  - rising and falling are high for exactly one clock, in the same cycle conditioned first shows its new value.
  - rising and falling are never both 1.
- T=1: conditioned follows sync1 one clock later. Every change still produces a one-cycle pulse.
- Pin toggling every clock indefinitely (T ≥ 2): conditioned never changes; no pulses.
- Mid-operation reset: counter and outputs clear immediately. A pulse in flight is truncated. No pulse is generated on reset release.
- Counter never exceeds T-1; no wrap-around is possible.

Decomposition:
- No shared package contents are required beyond the codebase's common defs include.
- Natural sub-module: sync_2ff, a 2-flop synchronizer with async active-low reset (ports clk, reset_n, d, q). Instantiated once for pin.
- Debounce counter and edge detection stay in input_conditioner.

Test Plan:
- Reset: reset_n=0 with pin=1 → conditioned=0, rising=0, falling=0 immediately; after release, conditioned rises at the 6th edge (T=4).
- Clean rise: T=4, pin 0→1 between edges (500-unit clock, change at odd offset) → conditioned=1 after exactly 6 edges; rising=1 for that one cycle only; falling stays 0.
- Clean fall: from conditioned=1, pin 1→0 → conditioned=0 after 6 edges; falling=1 for one cycle; rising stays 0.
- Glitch rejection: pin high for 3 clocks then low (T=4) → conditioned stays 0; no rising pulse; counter back to 0.
- Bounce: pin toggles every clock for 10 clocks, then stays 1 → single rising pulse, 6 edges after the final settle; conditioned=1.
- Random: 100 random pin values, each held 1000 time units (2 clocks) → conditioned changes only after runs of ≥2 equal samples that add up to ≥T stable clocks; every conditioned change is matched by exactly one rising/falling pulse; rising and falling are never 1 together.
